// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encodings and defaults for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STARTUP  = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/hazard_loaduse_det.sv
// rtl/hazard_loaduse_det.sv - combinational load-use compare between the ID instruction and the load in ID/EX
module hazard_loaduse_det (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == idex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == idex_rd);
    // x0 never carries a real dependency
    assign hazard  = idex_memread && (idex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush/freeze controller; HAZ_PERF_EN adds perf counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int STARTUP_FLUSH = 2,
    parameter int MEM_TIMEOUT   = MEM_TIMEOUT_DEF,
    parameter int TO_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        memwb_bubble,
`ifdef HAZ_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
`endif
    output logic        mem_timeout_err
);

    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] SF_INIT  = TO_W'(STARTUP_FLUSH);
    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

    hz_state_t       state;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_inc;
    logic            load_use;
    logic            mem_stall;
    logic            branch_go;

    hazard_loaduse_det u_loaduse (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .hazard       (load_use)
    );

    assign cnt_inc = cnt + CNT_ONE;

    // Once in MEM_WAIT the access is already outstanding, so only mem_ready matters
    always_comb begin
        mem_stall = 1'b0;
        if (state == ST_RUN)
            mem_stall = mem_req && !mem_ready;
        else if (state == ST_MEM_WAIT)
            mem_stall = !mem_ready;
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_hold    = 1'b0;
        memwb_bubble = 1'b0;
        branch_go    = 1'b0;
        if (state == ST_RUN || state == ST_MEM_WAIT) begin
            if (mem_stall) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                pipe_hold    = 1'b1;
                memwb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                branch_go  = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_STARTUP;
            cnt             <= SF_INIT;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_STARTUP: begin
                    // Leaving when cnt<=1 gives exactly STARTUP_FLUSH flush cycles
                    if (cnt <= CNT_ONE)
                        state <= ST_RUN;
                    else
                        cnt <= cnt - CNT_ONE;
                end
                ST_RUN: begin
                    if (mem_stall) begin
                        state <= ST_MEM_WAIT;
                        cnt   <= CNT_ONE;
                        if (TO_MAX == CNT_ONE)
                            mem_timeout_err <= 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= ST_RUN;
                    end else if (cnt != TO_MAX) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TO_MAX)
                            mem_timeout_err <= 1'b1;
                    end
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles <= 32'd0;
            perf_flushes      <= 32'd0;
        end else begin
            if ((state == ST_RUN || state == ST_MEM_WAIT) && !pc_write && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (branch_go && perf_flushes != 32'hFFFF_FFFF)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed check of hazard_ctrl against a cycle-count reference model
module tb_hazard_ctrl;

    localparam int STARTUP_FLUSH = 2;
    localparam int MEM_TIMEOUT   = 255;
    localparam int TO_W          = 8;
    localparam int SF_CYCLES     = (STARTUP_FLUSH == 0) ? 1 : STARTUP_FLUSH;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, idex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, idex_memread = 0;
    logic       ex_branch_taken = 0, mem_req = 0, mem_ready = 1;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, mem_timeout_err;
`ifdef HAZ_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flushes;
    int          m_stalls, m_flushes;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: cycles since reset release, length of current freeze run, sticky error
    int c;
    int run_len;
    bit m_err;

    hazard_ctrl #(
        .STARTUP_FLUSH (STARTUP_FLUSH),
        .MEM_TIMEOUT   (MEM_TIMEOUT),
        .TO_W          (TO_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .idex_memread    (idex_memread),
        .idex_rd         (idex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .pipe_hold       (pipe_hold),
        .memwb_bubble    (memwb_bubble),
`ifdef HAZ_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
`endif
        .mem_timeout_err (mem_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        return idex_memread && idex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == idex_rd) || (id_use_rs2 && id_rs2 == idex_rd));
    endfunction

    function automatic bit model_freeze();
        return (c >= SF_CYCLES) && !mem_ready && (run_len > 0 || mem_req);
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, mem_timeout_err}
    function automatic logic [6:0] model_outs();
        if (c < SF_CYCLES)       return {6'b001100, m_err};
        if (model_freeze())      return {6'b000011, m_err};
        if (ex_branch_taken)     return {6'b111100, m_err};
        if (model_load_use())    return {6'b000100, m_err};
        return {6'b110000, m_err};
    endfunction

    function automatic logic [6:0] dut_outs();
        return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, mem_timeout_err};
    endfunction

    task automatic model_reset();
        c = 0;
        run_len = 0;
        m_err = 0;
`ifdef HAZ_PERF_EN
        m_stalls = 0;
        m_flushes = 0;
`endif
    endtask

    task automatic model_step(input logic [6:0] exp);
`ifdef HAZ_PERF_EN
        if (c >= SF_CYCLES && !exp[6]) m_stalls++;
        if (c >= SF_CYCLES && exp[4] && exp[5]) m_flushes++;
`endif
        if (model_freeze()) begin
            run_len++;
            if (run_len >= MEM_TIMEOUT) m_err = 1;
        end else begin
            run_len = 0;
        end
        c++;
    endtask

    task automatic drive(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                         input logic br, input logic mq, input logic my);
        logic [6:0] exp;
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        idex_memread = mr; idex_rd = rd; ex_branch_taken = br; mem_req = mq; mem_ready = my;
        #1;
        exp = model_outs();
        check(tag, 32'(dut_outs()), 32'(exp));
        @(posedge clk);
        model_step(exp);
    endtask

    task automatic idle(input string tag);
        drive(tag, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outs", 32'(dut_outs()), 32'(7'b0011000));
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Startup flush window, then first fetch
        for (int i = 0; i < STARTUP_FLUSH + 1; i++) idle("startup");
        check("startup_pc_write", 32'(pc_write), 32'd1);

        // Load-use on rs2, then with rd=x0
        drive("loaduse_rs2", 5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 1);
        idle("loaduse_after");
        drive("loaduse_x0", 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 1);
        drive("loaduse_rs1", 5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 0, 1);
        drive("loaduse_unused", 5'd7, 5'd7, 0, 0, 1, 5'd7, 0, 0, 1);

        // Branch beats load-use
        drive("branch_vs_lu", 5'd3, 5'd3, 1, 1, 1, 5'd3, 1, 0, 1);

        // Single-cycle access does not stall
        drive("mem_1cyc", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);

        // Three-cycle freeze with a pending branch flushed on the ready cycle
        for (int i = 0; i < 3; i++) drive("mem_wait_br", 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
        drive("mem_ready_br", 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1);
        idle("post_wait");

        // Timeout: err rises after MEM_TIMEOUT freeze cycles and is sticky
        for (int i = 0; i < MEM_TIMEOUT + 5; i++)
            drive("timeout_wait", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        check("timeout_err_set", 32'(mem_timeout_err), 32'd1);
        drive("timeout_ready", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1);
        for (int i = 0; i < 3; i++) idle("timeout_sticky");
        check("timeout_err_sticky", 32'(mem_timeout_err), 32'd1);
        do_reset();
        check("timeout_err_clear", 32'(mem_timeout_err), 32'd0);
        for (int i = 0; i < STARTUP_FLUSH + 1; i++) idle("restart");

        // Async reset in the middle of MEM_WAIT
        for (int i = 0; i < 3; i++) drive("pre_async", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outs", 32'(dut_outs()), 32'(7'b0011000));
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                drive("random",
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 2) != 0));
            end
        end

`ifdef HAZ_PERF_EN
        check("perf_stalls", perf_stall_cycles, 32'(m_stalls));
        check("perf_flushes", perf_flushes, 32'(m_flushes));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
